// File: rtl/led_fade_pwm.sv
// LED fade/PWM driver: turns per-LED on/off requests into PWM brightness,
// ramping between dark and full brightness at a programmable rate.
module led_fade_pwm #(
  parameter int unsigned N_LEDS   = 10,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned STEP     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              fade_en,
  input  logic [N_LEDS-1:0] led_req,
  output logic [N_LEDS-1:0] led_out,
  output logic              pwm_sync,
  output logic              busy
);

  localparam int unsigned MAX   = (1 << PWM_BITS) - 1;
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PWM_BITS-1:0] MAX_L    = PWM_BITS'(MAX);
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(MAX - 1);
  localparam logic [PWM_BITS-1:0] STEP_L   = PWM_BITS'(STEP);
  localparam logic [PWM_BITS:0]   MAX_W    = (PWM_BITS + 1)'(MAX);
  localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS + 1)'(STEP);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [N_LEDS-1:0]                req_q;
  logic [N_LEDS-1:0][PWM_BITS-1:0]  level;
  logic [N_LEDS-1:0][PWM_BITS-1:0]  level_nxt;
  logic [N_LEDS-1:0]                mismatch;
  logic [N_LEDS-1:0]                duty_on;
  logic [PWM_BITS-1:0]              pwm_cnt;
  logic [PRE_W-1:0]                 pre_cnt;
  logic                             tick;

  // One fade step per PRESCALE cycles, only while running.
  assign tick = enable && (pre_cnt == PRE_LAST);

  for (genvar g = 0; g < N_LEDS; g++) begin : g_led
    logic [PWM_BITS-1:0] tgt;
    logic [PWM_BITS:0]   up_w;
    logic [PWM_BITS-1:0] up_sat;
    logic [PWM_BITS-1:0] dn_sat;

    assign tgt = req_q[g] ? MAX_L : '0;

    // Ramp arithmetic is one bit wider so the upward step saturates instead of wrapping.
    assign up_w   = {1'b0, level[g]} + STEP_W;
    assign up_sat = (up_w > MAX_W) ? MAX_L : up_w[PWM_BITS-1:0];
    assign dn_sat = (level[g] >= STEP_L) ? (level[g] - STEP_L) : '0;

    // Snap has priority over ramping; ramping only advances on a tick.
    assign level_nxt[g] = !fade_en           ? tgt    :
                          !tick              ? level[g] :
                          (level[g] < tgt)   ? up_sat :
                          (level[g] > tgt)   ? dn_sat :
                                               level[g];

    assign mismatch[g] = (level[g] != tgt);
    assign duty_on[g]  = (pwm_cnt < level[g]);
  end

  assign busy = |mismatch;

  // Request capture, level tracking, PWM/prescale counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q    <= '0;
      level    <= '0;
      pwm_cnt  <= '0;
      pre_cnt  <= '0;
      led_out  <= '0;
      pwm_sync <= 1'b0;
    end else begin
      req_q <= led_req;
      level <= level_nxt;
      if (enable) begin
        pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
        pre_cnt  <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
        pwm_sync <= (pwm_cnt == PWM_LAST);
        led_out  <= duty_on;
      end else begin
        pwm_cnt  <= '0;
        pre_cnt  <= '0;
        pwm_sync <= 1'b0;
        led_out  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm with PWM_BITS=8, PRESCALE=4, STEP=64.
module tb_led_fade_pwm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       fade_en;
  logic [9:0] led_req;
  logic [9:0] led_out;
  logic       pwm_sync;
  logic       busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  led_fade_pwm #(
    .N_LEDS  (10),
    .PWM_BITS(8),
    .PRESCALE(4),
    .STEP    (64)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .fade_en (fade_en),
    .led_req (led_req),
    .led_out (led_out),
    .pwm_sync(pwm_sync),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [9:0] req;
    logic [9:0] exp_out;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Bounded search for the next pwm_sync pulse.
  task automatic wait_sync(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (pwm_sync) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One full PWM period after a sync pulse: count on-cycles of LED0 and sync spacing.
  task automatic measure(input string nm, input int unsigned exp_ones);
    bit          ok;
    int unsigned ones;
    int unsigned syncs;
    int unsigned other;
    int unsigned last_sync;
    wait_sync(ok);
    chk({nm, "_sync_seen"}, 32'(ok), 32'd1);
    ones = 0; syncs = 0; other = 0; last_sync = 0;
    for (int unsigned i = 1; i <= 255; i++) begin
      step();
      if (led_out[0]) ones++;
      if (led_out[9:1] != 9'd0) other++;
      if (pwm_sync) begin
        syncs++;
        last_sync = i;
      end
    end
    chk({nm, "_ones"}, ones, exp_ones);
    chk({nm, "_sync_count"}, syncs, 32'd1);
    chk({nm, "_sync_period"}, last_sync, 32'd255);
    chk({nm, "_other_leds"}, other, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned errs;

    vecs[0] = '{1'b1, 10'h001, 10'h001, 1'b0};
    vecs[1] = '{1'b1, 10'h3FF, 10'h3FF, 1'b0};
    vecs[2] = '{1'b1, 10'h2AA, 10'h2AA, 1'b0};
    vecs[3] = '{1'b1, 10'h155, 10'h155, 1'b0};
    vecs[4] = '{1'b0, 10'h3FF, 10'h000, 1'b0};
    vecs[5] = '{1'b1, 10'h3FF, 10'h3FF, 1'b0};
    vecs[6] = '{1'b1, 10'h200, 10'h200, 1'b0};
    vecs[7] = '{1'b1, 10'h000, 10'h000, 1'b0};

    // Reset holds outputs dark even with all requests on.
    reset_n = 1'b0; enable = 1'b1; fade_en = 1'b0; led_req = 10'h3FF;
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (led_out != 10'h000 || busy || pwm_sync) errs++;
    end
    chk("reset_outputs", errs, 32'd0);

    // Ramp up: release with LED0 requested; ticks land on edges 4, 8, 12, 16.
    fade_en = 1'b1; led_req = 10'h001; reset_n = 1'b1;
    steps(3);
    chk("ramp_pre_tick_level", 32'(dut.level[0]), 32'd0);
    step();
    chk("ramp_t1_level", 32'(dut.level[0]), 32'd64);
    chk("ramp_t1_busy", 32'(busy), 32'd1);
    steps(4);
    chk("ramp_t2_level", 32'(dut.level[0]), 32'd128);
    steps(4);
    chk("ramp_t3_level", 32'(dut.level[0]), 32'd192);
    chk("ramp_t3_busy", 32'(busy), 32'd1);
    steps(4);
    chk("ramp_t4_level", 32'(dut.level[0]), 32'd255);
    chk("ramp_t4_busy", 32'(busy), 32'd0);
    measure("duty_full", 255);

    // Reset mid-operation, then ramp to 128 and reverse.
    reset_n = 1'b0;
    #1;
    chk("async_reset_level", 32'(dut.level[0]), 32'd0);
    chk("async_reset_out", 32'(led_out), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    step();
    reset_n = 1'b1;
    steps(4);
    chk("rev_up1_level", 32'(dut.level[0]), 32'd64);
    steps(4);
    chk("rev_up2_level", 32'(dut.level[0]), 32'd128);
    led_req = 10'h000;
    steps(4);
    chk("rev_dn1_level", 32'(dut.level[0]), 32'd64);
    chk("rev_dn1_busy", 32'(busy), 32'd1);
    steps(4);
    chk("rev_dn2_level", 32'(dut.level[0]), 32'd0);
    chk("rev_dn2_busy", 32'(busy), 32'd0);
    steps(2);
    chk("rev_out", 32'(led_out), 32'd0);
    measure("duty_zero", 0);

    // Enable gating at level 128, then re-enable and switch to snap mode.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1; led_req = 10'h001; enable = 1'b1; fade_en = 1'b1;
    steps(8);
    chk("gate_level_before", 32'(dut.level[0]), 32'd128);
    chk("gate_out_before", 32'(led_out), 32'h001);
    enable = 1'b0;
    step();
    chk("gate_out_off", 32'(led_out), 32'd0);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (led_out != 10'h000 || pwm_sync || dut.level[0] != 8'd128) errs++;
    end
    chk("gate_hold", errs, 32'd0);
    enable = 1'b1;
    steps(3);
    chk("reen_pre_tick_level", 32'(dut.level[0]), 32'd128);
    step();
    chk("reen_tick_level", 32'(dut.level[0]), 32'd192);
    fade_en = 1'b0;
    step();
    chk("fade_off_snap_level", 32'(dut.level[0]), 32'd255);

    // Snap-mode table: settled output equals request while enabled.
    for (int unsigned v = 0; v < 8; v++) begin
      enable  = vecs[v].en;
      led_req = vecs[v].req;
      steps(3);
      chk($sformatf("table%0d_out", v), 32'(led_out), 32'(vecs[v].exp_out));
      chk($sformatf("table%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
    end

    // Snap latency: busy for one cycle, LED lit from the third edge on.
    led_req = 10'h001;
    step();
    chk("snap_e1_busy", 32'(busy), 32'd1);
    chk("snap_e1_out", 32'(led_out), 32'd0);
    step();
    chk("snap_e2_busy", 32'(busy), 32'd0);
    chk("snap_e2_out", 32'(led_out), 32'd0);
    step();
    chk("snap_e3_out", 32'(led_out), 32'h001);
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (led_out != 10'h001) errs++;
    end
    chk("snap_steady", errs, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
